// File: rtl/ggt_sched_pkg.sv
// =============================================================================
// Module : ggt_pkg
// Brief  : Shared FSM encoding, default width and index helper for ggt_sched.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package ggt_pkg;

    localparam int C_DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Modulo-n increment without a divider.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ggt_sched_if.sv
// =============================================================================
// Module : ggt_sched_if
// Brief  : Request/response bundle between the requesters and the GCD scheduler.
// Rev    : 1.0
// =============================================================================
`default_nettype none

interface ggt_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = ggt_pkg::C_DEF_W
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_ggt;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_ggt, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_ggt, busy
    );
endinterface

`default_nettype wire

// File: rtl/ggt_sched_core.sv
// =============================================================================
// Module : ggt_core
// Brief  : Iterative subtractive GCD engine, one reduction step per cycle.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module ggt_core
    import ggt_pkg::*;
#(
    parameter int W = C_DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_result
);

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic         r_run;
    logic         w_term;

    assign w_term   = (r_a == r_b) || (r_a == '0) || (r_b == '0);
    // Combinational pulse so the scheduler leaves RUN on the terminating step.
    assign o_done   = r_run & w_term;
    assign o_result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (w_term) begin
                r_result <= (r_a == '0) ? r_b : r_a;
                r_run    <= 1'b0;
            end else if (r_a > r_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ggt_sched.sv
// =============================================================================
// Module : ggt_sched
// Brief  : Round-robin scheduler sharing one GCD engine among NREQ requesters.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module ggt_sched
    import ggt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = C_DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    ggt_sched_if.slave     bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_owner_nxt;
    logic [IW-1:0]   w_sel;
    logic            w_found;
    logic            w_start;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_done;
    logic [W-1:0]    w_result;

    // Scan offsets high to low so the lowest offset from r_ptr wins.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            j = int'(r_ptr) + off;
            if (j >= NREQ) j -= NREQ;
            if (bus.req_valid[j]) begin
                w_found = 1'b1;
                w_sel   = IW'(j);
            end
        end
        w_a = bus.req_a[int'(w_sel)*W +: W];
        w_b = bus.req_b[int'(w_sel)*W +: W];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_start       = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_ggt   = '0;
        bus.busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    bus.req_ready[w_sel] = 1'b1;
                    w_start              = 1'b1;
                    w_owner_nxt          = w_sel;
                    w_state_nxt          = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_done) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid[r_owner] = 1'b1;
                bus.rsp_ggt            = w_result;
                if (bus.rsp_ready[r_owner]) begin
                    w_ptr_nxt   = IW'(wrap_inc(int'(r_owner), NREQ));
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    ggt_core #(.W(W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_done   (w_done),
        .o_result (w_result)
    );

endmodule

`default_nettype wire

// File: tb/tb_ggt_sched.sv
// =============================================================================
// Module : tb_ggt_sched
// Brief  : Self-checking bench for ggt_sched: transaction-level model plus directed literals.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_ggt_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ggt_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    ggt_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int first_valid(input logic [NREQ-1:0] v, input int p);
        for (int o = 0; o < NREQ; o++)
            if (v[(p + o) % NREQ]) return (p + o) % NREQ;
        return -1;
    endfunction

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // Subtraction steps = sum of Euclid quotients minus one (the final equal pair stops it).
    function automatic int steps_ref(input int a, input int b);
        int x, y, s, t;
        if (a == 0 || b == 0) return 0;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        s = 0;
        while (y != 0) begin s += x / y; t = x % y; x = y; y = t; end
        return s - 1;
    endfunction

    bit m_live = 1'b0;
    bit m_busy = 1'b0;
    int m_cnt  = 0;
    int m_owner = 0;
    int m_ptr  = 0;
    int m_res  = 0;

    always @(negedge clk) begin : p_model
        int g;
        logic [NREQ-1:0] e_rdy, e_rv;
        logic [W-1:0]    e_g;
        logic            e_busy;
        g      = first_valid(bus.req_valid, m_ptr);
        e_rdy  = '0;
        e_rv   = '0;
        e_g    = '0;
        e_busy = m_busy;
        if (!m_busy) begin
            if (g >= 0) e_rdy[g] = 1'b1;
        end else if (m_cnt == 0) begin
            e_rv[m_owner] = 1'b1;
            e_g           = W'(m_res);
        end
        if (m_live) begin
            chk("mdl_req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("mdl_rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            chk("mdl_rsp_ggt",   32'(bus.rsp_ggt),   32'(e_g));
            chk("mdl_busy",      32'(bus.busy),      32'(e_busy));
        end
        if (rst) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_owner = g;
                m_res   = gcd_ref(int'(bus.req_a[g*W +: W]), int'(bus.req_b[g*W +: W]));
                m_cnt   = steps_ref(int'(bus.req_a[g*W +: W]), int'(bus.req_b[g*W +: W])) + 1;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (bus.rsp_ready[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input int a, input int b);
        bus.req_a[idx*W +: W] = W'(a);
        bus.req_b[idx*W +: W] = W'(b);
    endtask

    task automatic wait_any_ready(input string name, output int idx, output int t);
        idx = -1;
        t   = cyc;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) idx = i;
                t = cyc;
                return;
            end
        end
        chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_any_rsp(input string name, output int idx, output int t, output logic [W-1:0] g);
        idx = -1;
        t   = cyc;
        g   = '0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i]) idx = i;
                t = cyc;
                g = bus.rsp_ggt;
                return;
            end
        end
        chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_one(input string name, input int idx, input int a, input int b,
                           input int exp_res, input int exp_lat);
        int gi, ri, t0, t1;
        logic [W-1:0] g;
        tick();
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        set_ops(idx, a, b);
        wait_any_ready(name, gi, t0);
        chk({name, "_grant"}, 32'(gi), 32'(idx));
        tick();
        bus.req_valid = '0;
        wait_any_rsp(name, ri, t1, g);
        chk({name, "_owner"},   32'(ri),      32'(idx));
        chk({name, "_latency"}, 32'(t1 - t0), 32'(exp_lat));
        chk({name, "_result"},  32'(g),       32'(exp_res));
    endtask

    // ---------------- main sequence ----------------
    initial begin : p_stim
        int gi, ri, t0, t1;
        logic [W-1:0] g;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_ggt",   32'(bus.rsp_ggt),   32'd0);
        chk("reset_busy",      32'(bus.busy),      32'd0);

        run_one("g12_8", 0, 12, 8, 4, 4);
        run_one("g7_7",  1, 7,  7, 7, 2);
        run_one("g0_5",  2, 0,  5, 5, 2);
        run_one("g9_0",  3, 9,  0, 9, 2);

        // All four at once with the pointer back at 0.
        tick();
        bus.req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 48, 18);
        for (int n = 0; n < NREQ; n++) begin
            wait_any_ready("rr", gi, t0);
            chk("rr_order", 32'(gi), 32'(n));
            tick();
            if (gi >= 0) bus.req_valid[gi] = 1'b0;
            wait_any_rsp("rr", ri, t1, g);
            chk("rr_owner",  32'(ri), 32'(n));
            chk("rr_result", 32'(g),  32'd6);
        end

        // Pointer wrapped to 0: requester 0 beats 3.
        tick();
        bus.req_valid = 4'b1001;
        set_ops(0, 0, 0);
        set_ops(3, 5, 5);
        wait_any_ready("wrap", gi, t0);
        chk("wrap_grant", 32'(gi), 32'd0);
        tick();
        bus.req_valid = '0;
        wait_any_rsp("wrap", ri, t1, g);
        chk("wrap_g0_0", 32'(g), 32'd0);
        chk("wrap_lat",  32'(t1 - t0), 32'd2);

        // Backpressure on requester 2 while requester 0 waits.
        tick();
        bus.rsp_ready = 4'b1011;
        bus.req_valid = 4'b0100;
        set_ops(2, 20, 15);
        set_ops(0, 6, 4);
        wait_any_ready("bp", gi, t0);
        chk("bp_grant", 32'(gi), 32'd2);
        tick();
        bus.req_valid = 4'b0001;
        wait_any_rsp("bp", ri, t1, g);
        chk("bp_result", 32'(g), 32'd5);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'h4);
            chk("bp_hold_ggt",   32'(bus.rsp_ggt),   32'd5);
            chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.rsp_ready = '1;
        @(negedge clk);
        chk("bp_hs_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        wait_any_rsp("bp2", ri, t1, g);
        chk("bp2_result", 32'(g), 32'd2);

        // Long run with operands scrambled after accept.
        tick();
        bus.req_valid = 4'b0010;
        set_ops(1, 1, 255);
        wait_any_ready("long", gi, t0);
        tick();
        bus.req_valid = '0;
        bus.req_a     = W*NREQ'($urandom);
        bus.req_b     = W*NREQ'($urandom);
        wait_any_rsp("long", ri, t1, g);
        chk("long_latency", 32'(t1 - t0), 32'd256);
        chk("long_result",  32'(g),       32'd1);

        // Reset in RUN after pointer is left at 3.
        run_one("g3_6", 2, 3, 6, 3, 3);
        tick();
        bus.req_valid = 4'b1000;
        set_ops(3, 1, 255);
        wait_any_ready("rstrun", gi, t0);
        tick();
        bus.req_valid = '0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_ggt",   32'(bus.rsp_ggt),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        tick();
        bus.req_valid = 4'b1001;
        set_ops(0, 10, 4);
        @(negedge clk);
        chk("rst_restart_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        wait_any_rsp("rstre", ri, t1, g);
        chk("rstre_result", 32'(g), 32'd2);

        // Randomized traffic, mostly short operands, occasional reset.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst           = ($urandom_range(0, 499) == 0);
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) < 8) set_ops(i, $urandom_range(0, 31), $urandom_range(0, 31));
                else                          set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
                bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ggt_sched.md
# ggt_sched

Round-robin scheduler that shares one iterative subtractive GCD (GGT) engine among `NREQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The scheduler grants one requester at a time, sequences the engine to completion, and returns the result to that requester with a second valid/ready handshake. It sits between the per-channel operand sources and a single `ggt_core` instance.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand and result width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req_valid`, in, `NREQ`: bit i set means requester i offers an operand pair.
- `req_a`, in, `NREQ*W`: operand a. Requester i occupies bits `[i*W +: W]`.
- `req_b`, in, `NREQ*W`: operand b, same packing as `req_a`.
- `req_ready`, out, `NREQ`: one-hot accept. Transfer happens when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, `NREQ`: one-hot result valid for the served requester.
- `rsp_ggt`, out, `W`: result value. Shared by all requesters.
- `rsp_ready`, in, `NREQ`: bit i set means requester i accepts its result.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, RESP.
- IDLE
  - Select the first i with `req_valid[i]=1`, searching from pointer `ptr` upward and wrapping from NREQ-1 to 0.
  - Drive `req_ready[i]=1` combinationally in the same cycle. That cycle is the transfer.
  - Latch `req_a[i]`, `req_b[i]` and the owner index i. Next state is RUN.
  - If no request is valid, stay in IDLE.
- RUN: the engine registers (a, b) take one step per cycle.
  - If a==b, or a==0, or b==0: result = (a==0) ? b : a. Register the result; next state is RESP.
  - Otherwise, if a>b then a ← a−b, else b ← b−a. Stay in RUN.
  - All arithmetic is unsigned `W`-bit. Subtraction never underflows because the larger value is always reduced.
- RESP
  - `rsp_valid[owner]=1` and `rsp_ggt` = result, both held stable until `rsp_ready[owner]=1`.
  - On that handshake cycle: `ptr` ← (owner+1) mod NREQ, next state is IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is all-zero outside IDLE. New requests wait. They are not queued.
- Operands are captured at transfer. Later changes on `req_a`/`req_b` do not affect the running computation.
- gcd(0,0) = 0.

## Timing
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_ggt`=0, `busy`=0, engine registers 0.
- Request accepted in cycle T:
  - RUN begins at T+1.
  - With k = number of subtraction steps, `rsp_valid` first rises at T+2+k.
- Examples:
  - gcd(12,8): k=2, response at T+4, result 4.
  - gcd(7,7): k=0, response at T+2.
  - gcd(1,255): k=254, response at T+256.
- Worst case k = 2^W − 2.
- With `rsp_ready` already high, the response is consumed in its first cycle. IDLE returns the next cycle, so a new accept is possible at T+3+k.
- `rsp_ggt` is 0 whenever `rsp_valid` is all-zero.
- Reset asserted in any state: the in-flight request is dropped with no response. All outputs take their reset values on the next edge.
- Simultaneous requests: exactly one is granted per IDLE cycle, in round-robin order. Starvation is bounded at NREQ−1 services.

## Structure
- Package `ggt_pkg`: state encoding constants (IDLE, RUN, RESP) and the default width constant.
- Sub-module `ggt_core`:
  - Inputs: `start`, `a_in`, `b_in`.
  - Outputs: `done` (one-cycle pulse), `result`.
  - Contains the engine registers and the subtract/compare logic.
- The top level holds the arbiter, the pointer, the owner register and the FSM.

## Test plan
- Single request, requester 0, a=12, b=8: `req_ready[0]` high in the accept cycle; `rsp_valid`=4'b0001 and `rsp_ggt`=4 at T+4.
- All four requesters valid at once with `ptr`=0, each pair (48,18): grants in order 0,1,2,3; each result is 6; `ptr` wraps back to 0.
- Zero operands: (0,5) → 5 at T+2; (9,0) → 9; (0,0) → 0.
- Backpressure: `rsp_ready[2]` held low for 10 cycles. `rsp_valid[2]` and `rsp_ggt` stay stable, `req_ready` stays 0, and the next grant occurs only after the handshake.
- Long run (1,255): result 1 at T+256. `busy` stays high throughout, and operand changes after the accept have no effect.
- `rst` pulsed while in RUN: all outputs are 0 on the next cycle, no response is issued, and arbitration restarts from requester 0.
